// File: rtl/pipe_adder_n.sv
// pipe_adder_n: valid/ready pipelined adder/subtractor.
// A WIDTH-bit add (or A + ~B + 1 subtract) is split into STAGES chunks of
// CHUNK = WIDTH/STAGES bits; stage k resolves chunk k and hands its carry on.
// Latency is STAGES cycles, throughput one op per cycle. Backpressure
// ripples combinationally from out_ready to in_ready; there is no skid buffer.
// Optional build macro: PIPE_ADDER_SAT_EN. When defined, an overflowing
// result is clamped to the most positive / most negative value in the last
// stage. cout and ovf are unaffected.
module pipe_adder_n #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  // Occupancy of each stage register.
  logic [STAGES-1:0] valid_q;
  // adv[k]: stage k loads from its predecessor this cycle; adv[STAGES] is the consumer.
  logic [STAGES:0]   adv;
  // v_in[k]: the item offered to stage k is real (not a bubble).
  logic [STAGES-1:0] v_in;

  // Stage-k inputs. Operands are kept shifted so the chunk stage k works on
  // always sits in the low CHUNK bits; the result keeps its final bit layout.
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_res [STAGES];
  logic             st_c   [STAGES];

  // Final-stage output registers.
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // Backpressure chain: a stage may load when it is empty or its content moves on.
  always_comb begin
    adv = '0;
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !valid_q[k] || adv[k+1];
    end
  end

  // Valid bit offered to each stage: the external request for stage 0,
  // otherwise the predecessor's occupancy.
  always_comb begin
    v_in = '0;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = valid_q[k-1];
    end
  end

  // Stage valid bits; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          valid_q[k] <= v_in[k];
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Stage 0 takes the effective operands straight from the ports: subtract
  // inverts B and forces the carry-in to 1, ignoring cin.
  assign st_a[0]   = a;
  assign st_b[0]   = sub ? ~b : b;
  assign st_c[0]   = sub | cin;
  assign st_res[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [CHUNK:0]   add_w;
      logic [WIDTH-1:0] res_d;

      // Chunk adder: low CHUNK bits of the shifted operands plus incoming carry.
      assign add_w = {1'b0, st_a[gi][CHUNK-1:0]}
                   + {1'b0, st_b[gi][CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, st_c[gi]};

      // Merge this chunk into the partial result from earlier stages.
      always_comb begin
        res_d = st_res[gi];
        res_d[gi*CHUNK +: CHUNK] = add_w[CHUNK-1:0];
      end

      if (gi < STAGES - 1) begin : g_mid
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] res_q;
        logic             c_q;

        // Capture partial result and carry, shift the unconsumed operand bits down.
        always_ff @(posedge clk) begin
          if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            c_q   <= 1'b0;
          end else if (adv[gi] && v_in[gi]) begin
            a_q   <= st_a[gi] >> CHUNK;
            b_q   <= st_b[gi] >> CHUNK;
            res_q <= res_d;
            c_q   <= add_w[CHUNK];
          end
        end

        assign st_a[gi+1]   = a_q;
        assign st_b[gi+1]   = b_q;
        assign st_res[gi+1] = res_d_pass(res_q);
        assign st_c[gi+1]   = c_q;
      end else begin : g_last
        logic             ovf_d;
        logic [WIDTH-1:0] sum_d;

        // Signed overflow: carry into the MSB differs from carry out of it.
        // The MSB's carry-in is recovered from its operand and sum bits.
        assign ovf_d = (st_a[gi][CHUNK-1] ^ st_b[gi][CHUNK-1] ^ add_w[CHUNK-1])
                     ^ add_w[CHUNK];

`ifdef PIPE_ADDER_SAT_EN
        // On overflow the raw sign is inverted: a raw negative result means
        // both operands were non-negative, so clamp to the positive limit.
        always_comb begin
          sum_d = res_d;
          if (ovf_d) begin
            sum_d = res_d[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                   : {1'b1, {(WIDTH-1){1'b0}}};
          end
        end
`else
        // Raw wrapped result.
        always_comb begin
          sum_d = res_d;
        end
`endif

        // Output register: holds steady while the consumer stalls.
        always_ff @(posedge clk) begin
          if (reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
          end else if (adv[gi] && v_in[gi]) begin
            sum_q  <= sum_d;
            cout_q <= add_w[CHUNK];
            ovf_q  <= ovf_d;
          end
        end
      end
    end
  endgenerate

  // Identity helper so the partial result passes between stages unchanged.
  function automatic logic [WIDTH-1:0] res_d_pass(input logic [WIDTH-1:0] v);
    return v;
  endfunction

endmodule

// File: tb/tb_pipe_adder_n.sv
// tb_pipe_adder_n: directed tests for pipe_adder_n (WIDTH=32, STAGES=4)
// with a word-level reference model and a per-cycle output checker.
module tb_pipe_adder_n;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  res_t exp_q[$];

  logic        held_valid = 1'b0;
  logic [31:0] held_sum;
  logic        held_cout;
  logic        held_ovf;

  pipe_adder_n #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-word reference: 33-bit add of effective operands.
  function automatic res_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic ci, input logic sb);
    res_t        r;
    logic [31:0] eb;
    logic [32:0] full;
    eb   = sb ? ~bv : bv;
    full = {1'b0, av} + {1'b0, eb} + {32'd0, (sb | ci)};
    r.s  = full[31:0];
    r.c  = full[32];
    r.o  = (av[31] == eb[31]) && (full[31] != av[31]);
`ifdef PIPE_ADDER_SAT_EN
    if (r.o) r.s = av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model queue, plus stall-hold checks.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_sum",   {32'd0, sum},  {32'd0, held_sum});
        chk("hold_cout",  {63'd0, cout}, {63'd0, held_cout});
        chk("hold_ovf",   {63'd0, ovf},  {63'd0, held_ovf});
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", {63'd0, out_valid}, 64'd0);
        end else begin
          chk("model_sum",  {32'd0, sum},  {32'd0, exp_q[0].s});
          chk("model_cout", {63'd0, cout}, {63'd0, exp_q[0].c});
          chk("model_ovf",  {63'd0, ovf},  {63'd0, exp_q[0].o});
          if (out_ready) void'(exp_q.pop_front());
        end
        if (out_ready) n_out++;
        held_valid = !out_ready;
        held_sum   = sum;
        held_cout  = cout;
        held_ovf   = ovf;
      end else begin
        held_valid = 1'b0;
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  // One op into an empty pipe: checks acceptance, 4-cycle latency and literal result.
  task automatic run_single(input string name, input logic [31:0] av, input logic [31:0] bv,
                            input logic ci, input logic sb, input logic [31:0] es,
                            input logic ec, input logic eo);
    int lat;
    bit seen;
    @(posedge clk); #1;
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    chk({name, "_latency"}, 64'(lat), 64'd4);
    if (seen) begin
      chk({name, "_sum"},  {32'd0, sum},  {32'd0, es});
      chk({name, "_cout"}, {63'd0, cout}, {63'd0, ec});
      chk({name, "_ovf"},  {63'd0, ovf},  {63'd0, eo});
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_op(input int idx);
    a   = 32'h0123_4567 + 32'(idx) * 32'h0000_1111;
    b   = 32'(idx) * 32'h0F0F_0F0F;
    cin = 1'b0;
    sub = idx[0];
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ov_hist;
    int          idx;
    int          accepts;
    int          n_out0;
    bit          acc;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum",       {32'd0, sum},       64'd0);
    chk("rst_cout",      {63'd0, cout},      64'd0);
    chk("rst_ovf",       {63'd0, ovf},       64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);

    // Directed single ops with hand-computed results.
    run_single("carry_chunk", 32'h0000_0FFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 1'b0);
    run_single("full_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
`ifdef PIPE_ADDER_SAT_EN
    run_single("pos_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
`else
    run_single("pos_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`endif
    run_single("sub_neg",     32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_single("sub_cin_ign", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
`ifdef PIPE_ADDER_SAT_EN
    run_single("neg_ovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
    run_single("neg_ovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
    run_single("cin_add",     32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0);

    // Back-to-back stream of 10 ops; results must come out on 10 consecutive cycles.
    ov_hist = '0;
    for (int j = 0; j < 16; j++) begin
      @(posedge clk); #1;
      if (j < 10) begin
        a = 32'(j); b = 32'(j) << 28; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      ov_hist[j] = out_valid;
      if (j < 10) chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
    end
    chk("stream_pattern", {48'd0, ov_hist}, 64'h3FF0);

    // Stall: consumer blocked, pipe fills after 4 accepts and holds op 0.
    n_out0  = n_out;
    idx     = 0;
    accepts = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_op(idx);
    in_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) accepts++;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        drive_op(idx);
      end
    end
    @(negedge clk);
    chk("stall_accepts",   64'(accepts), 64'd4);
    chk("stall_in_ready",  {63'd0, in_ready},  64'd0);
    chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
    chk("stall_first_sum", {32'd0, sum}, 64'h0123_4567);

    // Release and keep streaming until 8 ops total, then drain.
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int g = 0; g < 40 && idx < 8; g++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (idx < 8) drive_op(idx);
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("drain_count", 64'(n_out - n_out0), 64'd8);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    // Reset with three ops in flight: all must vanish.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      a = 32'h1111_0000 + 32'(k); b = 32'h0000_0100; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_sum",       {32'd0, sum},       64'd0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("midrst_no_stale", {63'd0, out_valid}, 64'd0);
    end
    run_single("post_rst", 32'h0000_00FF, 32'h0000_0F01, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
